// File: rtl/uart_mike_rx_if.sv
// Receive-side bundle between the UART_MIKE receiver and its control FSM.
// master = receiver (drives byte/status), slave = control FSM (drives rx_flag_clr).
interface uart_mike_rx_if;
    logic       rx_flag_clr;
    logic       rx_start;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_overrun;
    logic       rx_parity_err;

    modport master (
        input  rx_flag_clr,
        output rx_start, rx_done, rx_data, rx_valid,
        output rx_frame_err, rx_overrun, rx_parity_err
    );

    modport slave (
        output rx_flag_clr,
        input  rx_start, rx_done, rx_data, rx_valid,
        input  rx_frame_err, rx_overrun, rx_parity_err
    );
endinterface

// File: rtl/uart_mike_rx.sv
// UART 8N1 receiver (8E1 when UART_MIKE_RX_PARITY_EN is defined); 2-flop sync, mid-bit sampling.
// Latency: rx_start 2+CLKS_PER_BIT/2 clks after the line falls; rx_done 9 (10) bit periods later.
// No backpressure: a new byte overwrites rx_data and raises rx_overrun if rx_valid is still set.
module uart_mike_rx #(
    parameter  int CLKS_PER_BIT = 434,
    localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic           i_clk,
    input  logic           i_n_rst,
    input  logic           i_rx_in,
    uart_mike_rx_if.master rx_if
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_MIKE_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_sync1;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_timer;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_rx_start;
    logic             r_rx_done;
    logic [7:0]       r_rx_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic w_half;
    logic w_full;
    logic w_start_evt;
    logic w_done_evt;
    logic w_bit_smp;
    logic w_timer_rst;

    assign w_half = (r_timer == CNT_W'(CLKS_PER_BIT / 2 - 1));
    assign w_full = (r_timer == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (!r_rx_s) w_next = S_START;
            S_START:  if (w_half) w_next = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_MIKE_RX_PARITY_EN
            S_DATA:   if (w_full && r_bit_idx == 3'd7) w_next = S_PARITY;
            S_PARITY: if (w_full) w_next = S_STOP;
`else
            S_DATA:   if (w_full && r_bit_idx == 3'd7) w_next = S_STOP;
`endif
            S_STOP:   if (w_full) w_next = r_rx_s ? S_IDLE : S_BREAK;
            S_BREAK:  if (r_rx_s) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start_evt = (r_state == S_START) && w_half && !r_rx_s;
        w_done_evt  = (r_state == S_STOP) && w_full;
        w_bit_smp   = (r_state == S_DATA) && w_full;
        // Timer only runs while inside a bit period; it restarts on every bit boundary.
        w_timer_rst = (w_next != r_state) || w_full ||
                      (r_state == S_IDLE) || (r_state == S_BREAK);
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_sync1     <= 1'b1;
            r_rx_s      <= 1'b1;
            r_timer     <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_start  <= 1'b0;
            r_rx_done   <= 1'b0;
            r_rx_data   <= 8'h00;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sync1    <= i_rx_in;
            r_rx_s     <= r_sync1;
            r_timer    <= w_timer_rst ? '0 : r_timer + CNT_W'(1);
            r_rx_start <= w_start_evt;
            r_rx_done  <= w_done_evt;
            if (w_start_evt) r_bit_idx <= 3'd0;
            if (w_bit_smp) begin
                r_shift[r_bit_idx] <= r_rx_s;
                r_bit_idx          <= r_bit_idx + 3'd1;
            end
            if (w_done_evt) r_rx_data <= r_shift;
            // Set terms are ORed after the clear so a new frame wins over a same-cycle clear.
            r_valid     <= (r_valid & ~rx_if.rx_flag_clr) | w_done_evt;
            r_overrun   <= (r_overrun & ~rx_if.rx_flag_clr) | (w_done_evt & r_valid);
            r_frame_err <= (r_frame_err & ~rx_if.rx_flag_clr) | (w_done_evt & ~r_rx_s);
        end
    end

`ifdef UART_MIKE_RX_PARITY_EN
    logic r_par_bad;
    logic r_parity_err;

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            // Even parity: data bits XOR parity bit must be 0.
            if ((r_state == S_PARITY) && w_full) r_par_bad <= r_rx_s ^ (^r_shift);
            r_parity_err <= (r_parity_err & ~rx_if.rx_flag_clr) | (w_done_evt & r_par_bad);
        end
    end

    assign rx_if.rx_parity_err = r_parity_err;
`else
    assign rx_if.rx_parity_err = 1'b0;
`endif

    assign rx_if.rx_start     = r_rx_start;
    assign rx_if.rx_done      = r_rx_done;
    assign rx_if.rx_data      = r_rx_data;
    assign rx_if.rx_valid     = r_valid;
    assign rx_if.rx_frame_err = r_frame_err;
    assign rx_if.rx_overrun   = r_overrun;
endmodule

// File: tb/tb_uart_mike_rx.sv
// Bench for uart_mike_rx at CLKS_PER_BIT=8: frame-level event model plus literal spot checks.
module tb_uart_mike_rx;
    localparam int CPB  = 8;
    localparam int MAXC = 4096;
`ifdef UART_MIKE_RX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    logic n_rst;
    logic rx_in;

    uart_mike_rx_if u_if ();

    uart_mike_rx #(.CLKS_PER_BIT(CPB)) u_dut (
        .i_clk   (clk),
        .i_n_rst (n_rst),
        .i_rx_in (rx_in),
        .rx_if   (u_if)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_fall       = 0;
    int last_start_cyc  = -1;
    int last_done_cyc   = -1;
    bit chk_en = 0;

    // Expected events, indexed by the posedge count at which the DUT registers them.
    bit       exp_start [0:MAXC-1];
    bit       exp_done  [0:MAXC-1];
    bit [7:0] exp_dat   [0:MAXC-1];
    bit       exp_fe    [0:MAXC-1];
    bit       exp_pe    [0:MAXC-1];

    logic       m_start, m_done, m_valid, m_fe, m_ovr, m_pe;
    logic [7:0] m_data;

    always @(posedge clk) begin
        logic d;
        logic c;
        cyc = cyc + 1;
        d = (cyc < MAXC) ? exp_done[cyc] : 1'b0;
        c = u_if.rx_flag_clr;
        if (!n_rst) begin
            chk_en  = 1;
            m_start = 0; m_done = 0; m_valid = 0;
            m_fe = 0; m_ovr = 0; m_pe = 0; m_data = 8'h00;
        end else begin
            m_start = (cyc < MAXC) ? exp_start[cyc] : 1'b0;
            m_done  = d;
            m_ovr   = (c ? 1'b0 : m_ovr) | (d & m_valid);
            m_fe    = (c ? 1'b0 : m_fe)  | (d & exp_fe[cyc]);
            m_pe    = (c ? 1'b0 : m_pe)  | (d & exp_pe[cyc]);
            m_valid = (c ? 1'b0 : m_valid) | d;
            if (d) m_data = exp_dat[cyc];
        end
    end

    always @(negedge clk) begin
        logic [13:0] act;
        logic [13:0] exp;
        if (chk_en) begin
            act = {u_if.rx_start, u_if.rx_done, u_if.rx_data, u_if.rx_valid,
                   u_if.rx_frame_err, u_if.rx_overrun, u_if.rx_parity_err};
            exp = {m_start, m_done, m_data, m_valid, m_fe, m_ovr, m_pe};
            n_tests = n_tests + 1;
            if (act !== exp) begin
                n_fail = n_fail + 1;
                $display("FAIL cycle_model cyc=%0d got {start,done,data,valid,fe,ovr,pe}=%b expected %b",
                         cyc, act, exp);
            end
            if (u_if.rx_start === 1'b1) last_start_cyc = cyc;
            if (u_if.rx_done === 1'b1)  last_done_cyc  = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests = n_tests + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 u_if.rx_flag_clr = 1'b1;
        @(posedge clk); #1 u_if.rx_flag_clr = 1'b0;
        idle(2);
    endtask

    // Drives one frame cycle by cycle; optionally clears flags in the rx_done cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip,
                              input bit clr_at_done, input int low_after);
        logic [10:0] bits;
        int f;
        int ds;
        @(posedge clk); #1;
        f = cyc + 1;
        last_fall = f;
        bits = '1;
        bits[0]   = 1'b0;
        bits[8:1] = d;
`ifdef UART_MIKE_RX_PARITY_EN
        bits[9]  = (^d) ^ par_flip;
        bits[10] = stop_b;
`else
        bits[9]  = stop_b;
`endif
        ds = f + CPB / 2 + 2 + CPB * (NB - 1);
        exp_start[f + CPB / 2 + 2] = 1'b1;
        exp_done[ds] = 1'b1;
        exp_dat[ds]  = d;
        exp_fe[ds]   = ~stop_b;
`ifdef UART_MIKE_RX_PARITY_EN
        exp_pe[ds]   = par_flip;
`else
        exp_pe[ds]   = 1'b0;
`endif
        for (int t = 0; t < NB * CPB; t++) begin
            rx_in = bits[t / CPB];
            u_if.rx_flag_clr = clr_at_done && (cyc + 1 == ds);
            @(posedge clk); #1;
        end
        u_if.rx_flag_clr = 1'b0;
        if (low_after > 0) begin
            rx_in = 1'b0;
            idle(low_after);
        end
        rx_in = 1'b1;
        idle(12);
    endtask

    initial begin
        int saved_done;
        n_rst = 1'b0;
        rx_in = 1'b1;
        u_if.rx_flag_clr = 1'b0;

        // Reset with the line toggling.
        repeat (4) begin
            @(posedge clk); #1 rx_in = ~rx_in;
        end
        rx_in = 1'b1;
        idle(1);
        check("reset_outputs", {18'd0, u_if.rx_start, u_if.rx_done, u_if.rx_data, u_if.rx_valid,
              u_if.rx_frame_err, u_if.rx_overrun, u_if.rx_parity_err}, 32'd0);
        n_rst = 1'b1;
        idle(5);

        // Clean byte with latency checks.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 0);
        check("a5_start_latency", last_start_cyc - last_fall, 32'd6);
        check("a5_done_latency", last_done_cyc - last_start_cyc, CPB * (NB - 1));
        check("a5_data", u_if.rx_data, 32'hA5);
        check("a5_valid", u_if.rx_valid, 32'd1);
        check("a5_errs", {u_if.rx_frame_err, u_if.rx_overrun, u_if.rx_parity_err}, 32'd0);
        pulse_clr();
        check("a5_clr_valid", u_if.rx_valid, 32'd0);
        check("a5_clr_data_kept", u_if.rx_data, 32'hA5);

        // Two-cycle glitch must not start a frame.
        saved_done = last_start_cyc;
        @(posedge clk); #1 rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx_in = 1'b1;
        idle(20);
        check("glitch_no_start", last_start_cyc, saved_done);
        check("glitch_data", u_if.rx_data, 32'hA5);

        // Framing error with the line held low afterwards.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 20);
        check("fe_data", u_if.rx_data, 32'h3C);
        check("fe_flag", u_if.rx_frame_err, 32'd1);
        check("fe_single_start", last_start_cyc - last_fall, 32'd6);
        pulse_clr();
        check("fe_clr", u_if.rx_frame_err, 32'd0);

        // Overrun, newest byte wins.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 0);
        check("ovr_flag", u_if.rx_overrun, 32'd1);
        check("ovr_data", u_if.rx_data, 32'h22);
        pulse_clr();
        check("ovr_clr", {u_if.rx_valid, u_if.rx_overrun}, 32'd0);

        // Clear coinciding with rx_done: set wins.
        send_frame(8'h33, 1'b1, 1'b0, 1'b0, 0);
        send_frame(8'h44, 1'b1, 1'b0, 1'b1, 0);
        check("clr_same_valid", u_if.rx_valid, 32'd1);
        check("clr_same_ovr", u_if.rx_overrun, 32'd1);
        check("clr_same_data", u_if.rx_data, 32'h44);
        pulse_clr();

`ifdef UART_MIKE_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 0);
        check("par_bad_flag", u_if.rx_parity_err, 32'd1);
        check("par_bad_data", u_if.rx_data, 32'h07);
        pulse_clr();
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 0);
        check("par_ok_flag", u_if.rx_parity_err, 32'd0);
        pulse_clr();
`endif

        // Reset in the middle of a frame discards it.
        saved_done = last_done_cyc;
        @(posedge clk); #1 rx_in = 1'b0;
        exp_start[cyc + 1 + CPB / 2 + 2] = 1'b1;
        idle(30);
        n_rst = 1'b0;
        rx_in = 1'b1;
        idle(2);
        n_rst = 1'b1;
        idle(100);
        check("midreset_no_done", last_done_cyc, saved_done);
        check("midreset_valid", u_if.rx_valid, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
